// File: rtl/timer_pkg.sv
// Shared definitions for the interval timer arbiter.
//   state_t   : controller state encoding (IDLE / RUN / DONE)
//   DEF_NREQ  : default number of requesters
//   DEF_WIDTH : default counter / interval width in bits
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_NREQ  = 4;
   localparam int DEF_WIDTH = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req    : per-requester request vector
//   ptr    : highest-priority index for this decision
//   en     : when low, no grant is issued
//   gnt    : one-hot grant
//   gnt_id : encoded index of the granted requester (0 when nothing granted)
module rr_arbiter
   import timer_pkg::*;
#(
   parameter int  NREQ = DEF_NREQ,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   input  logic            en,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gnt_id
);

   logic found;

   // Two passes give the wrap-around scan: first ptr..NREQ-1, then 0..ptr-1.
   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      found  = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (en && !found && req[i] && (i >= int'(ptr))) begin
            gnt[i] = 1'b1;
            gnt_id = IDW'(i);
            found  = 1'b1;
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (en && !found && req[i] && (i < int'(ptr))) begin
            gnt[i] = 1'b1;
            gnt_id = IDW'(i);
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/interval_timer_arbiter.sv
// Shares one down-counter between NREQ requesters. A round-robin arbiter
// picks one requester at a time; its interval is counted down and a
// one-cycle done pulse tagged with the requester id is returned.
//
//   state | meaning
//   IDLE  | waiting for a request; req_ready offers the round-robin winner
//   RUN   | counting the granted interval down; abort ends it early
//   DONE  | one-cycle completion pulse (done_valid, done_id, done_abort)
//
// Ports:
//   clk, rst         : clock, asynchronous active-low reset
//   req_valid        : per-requester request
//   req_len          : packed interval lengths, requester i at [i*WIDTH +: WIDTH]
//   req_ready        : one-hot accept, combinational from state and pointer
//   abort            : end the running interval early
//   busy             : high in RUN and DONE
//   grant_id         : current or last granted requester
//   cnt_q            : remaining count
//   done_valid/id    : completion pulse and its requester id
//   done_abort       : completion was caused by abort
module interval_timer_arbiter
   import timer_pkg::*;
#(
   parameter int  NREQ  = DEF_NREQ,
   parameter int  WIDTH = DEF_WIDTH,
   localparam int IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_len,
   output logic [NREQ-1:0]       req_ready,
   input  logic                  abort,
   output logic                  busy,
   output logic [IDW-1:0]        grant_id,
   output logic [WIDTH-1:0]      cnt_q,
   output logic                  done_valid,
   output logic [IDW-1:0]        done_id,
   output logic                  done_abort
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_d;
   logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]   grant_id_q, grant_id_d;
   logic             done_abort_q, done_abort_d;
   logic [NREQ-1:0]  arb_gnt;
   logic [IDW-1:0]   arb_id;
   logic             arb_en;
   logic [WIDTH-1:0] sel_len;

   // rst in the enable keeps req_ready low for the whole reset window.
   assign arb_en = (state_q == IDLE) && rst;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req    (req_valid),
      .ptr    (rr_ptr_q),
      .en     (arb_en),
      .gnt    (arb_gnt),
      .gnt_id (arb_id)
   );

   assign req_ready = arb_gnt;
   assign sel_len   = req_len[arb_id*WIDTH +: WIDTH];

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      rr_ptr_d     = rr_ptr_q;
      grant_id_d   = grant_id_q;
      done_abort_d = done_abort_q;
      unique case (state_q)
         IDLE: begin
            if (|(req_valid & arb_gnt)) begin
               // A zero-length request still occupies one counting cycle.
               cnt_d      = (sel_len == '0) ? WIDTH'(1) : sel_len;
               grant_id_d = arb_id;
               rr_ptr_d   = (int'(arb_id) == NREQ-1) ? '0 : arb_id + 1'b1;
               state_d    = RUN;
            end
         end
         RUN: begin
            if (abort) begin
               cnt_d        = '0;
               done_abort_d = 1'b1;
               state_d      = DONE;
            end else if (cnt_q <= WIDTH'(1)) begin
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DONE: begin
            done_abort_d = 1'b0;
            state_d      = IDLE;
         end
         default: begin
            cnt_d        = '0;
            done_abort_d = 1'b0;
            state_d      = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         rr_ptr_q     <= '0;
         grant_id_q   <= '0;
         done_abort_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         rr_ptr_q     <= rr_ptr_d;
         grant_id_q   <= grant_id_d;
         done_abort_q <= done_abort_d;
      end
   end

   assign busy       = (state_q != IDLE);
   assign done_valid = (state_q == DONE);
   assign done_id    = grant_id_q;
   assign grant_id   = grant_id_q;
   assign done_abort = done_abort_q;

endmodule

// File: tb/tb_interval_timer_arbiter.sv
module tb_interval_timer_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 4;
   localparam int IDW   = 2;

   logic                  clk = 1'b0;
   logic                  rst = 1'b0;
   logic [NREQ-1:0]       req_valid = '0;
   logic [NREQ*WIDTH-1:0] req_len = '0;
   logic                  abort = 1'b0;
   logic [NREQ-1:0]       req_ready;
   logic                  busy;
   logic [IDW-1:0]        grant_id;
   logic [WIDTH-1:0]      cnt_q;
   logic                  done_valid;
   logic [IDW-1:0]        done_id;
   logic                  done_abort;

   interval_timer_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_len    (req_len),
      .req_ready  (req_ready),
      .abort      (abort),
      .busy       (busy),
      .grant_id   (grant_id),
      .cnt_q      (cnt_q),
      .done_valid (done_valid),
      .done_id    (done_id),
      .done_abort (done_abort)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
   endtask

   // ---------------- behavioural model ----------------
   // A job is described by its id, effective length L, elapsed cycles t since
   // the accept edge and the cycle index at which its done pulse occurs.
   bit m_active  = 1'b0;
   bit m_aborted = 1'b0;
   int m_id = 0, m_len = 0, m_t = 0, m_end = 0, m_ptr = 0;
   int m_pick;

   function automatic int pick(input logic [NREQ-1:0] rv, input int p);
      for (int k = 0; k < NREQ; k++)
         if (rv[(p + k) % NREQ]) return (p + k) % NREQ;
      return -1;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_active = 1'b0; m_aborted = 1'b0;
         m_id = 0; m_len = 0; m_t = 0; m_end = 0; m_ptr = 0;
      end else if (m_active) begin
         if (m_t == m_end) begin
            m_active = 1'b0;
         end else begin
            if (abort) begin
               m_aborted = 1'b1;
               m_end     = m_t + 1;
            end
            m_t++;
         end
      end else begin
         m_pick = pick(req_valid, m_ptr);
         if (m_pick >= 0) begin
            m_active  = 1'b1;
            m_aborted = 1'b0;
            m_id      = m_pick;
            m_len     = int'(req_len[m_pick*WIDTH +: WIDTH]);
            if (m_len == 0) m_len = 1;
            m_t       = 0;
            m_end     = m_len;
            m_ptr     = (m_pick + 1) % NREQ;
         end
      end
   end

   logic [NREQ-1:0] cmp_er;
   int              cmp_p;
   bit              cmp_done;

   always @(negedge clk) begin
      cmp_er = '0;
      if (rst && !m_active) begin
         cmp_p = pick(req_valid, m_ptr);
         if (cmp_p >= 0) cmp_er[cmp_p] = 1'b1;
      end
      cmp_done = m_active && (m_t == m_end);
      chk("req_ready", 32'(req_ready), 32'(cmp_er));
      chk("busy", 32'(busy), 32'(m_active));
      chk("cnt_q", 32'(cnt_q), (!m_active || m_t >= m_end) ? 0 : 32'(m_len - m_t));
      chk("done_valid", 32'(done_valid), 32'(cmp_done));
      chk("grant_id", 32'(grant_id), 32'(m_id));
      chk("done_abort", 32'(done_abort), 32'(cmp_done && m_aborted));
      if (cmp_done) chk("done_id", 32'(done_id), 32'(m_id));
   end

   // ---------------- directed stimulus ----------------
   task automatic do_req(input int id, input int len, input int abort_cnt,
                         output int lat, output int did, output int dab);
      bit got;
      bit fired;
      got = 1'b0; fired = 1'b0; lat = -1; did = -1; dab = -1;
      req_len[id*WIDTH +: WIDTH] = WIDTH'(len);
      req_valid = NREQ'(1 << id);
      for (int k = 0; k < 30 && !got; k++) begin
         @(negedge clk);
         if (req_ready[id]) got = 1'b1;
      end
      if (!got) begin
         timeout("accept");
         req_valid = '0;
         return;
      end
      chk("ready_onehot", 32'(req_ready), 32'(1 << id));
      @(posedge clk); #1;
      req_valid = '0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done_valid) begin
            lat = k; did = int'(done_id); dab = int'(done_abort);
            return;
         end
         if (!fired && abort_cnt > 0 && int'(cnt_q) == abort_cnt) begin
            fired = 1'b1;
            #1 abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
         end
      end
      timeout("done");
   endtask

   int lat, did, dab, n;
   int ids[6];
   int stamps[6];
   int exp_order[6] = '{0, 1, 2, 3, 0, 1};
   bit hit;

   initial begin
      // 1. reset; req_ready must stay low while rst is asserted
      rst = 1'b0;
      req_valid = '1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_busy", 32'(busy), 0);
      req_valid = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("idle_cnt", 32'(cnt_q), 0);
      chk("idle_done", 32'(done_valid), 0);
      chk("idle_grant", 32'(grant_id), 0);
      chk("idle_ready", 32'(req_ready), 0);

      // 3. fairness: everyone requesting len 2
      req_len = {4{4'd2}};
      req_valid = '1;
      n = 0;
      for (int k = 0; k < 200 && n < 6; k++) begin
         @(negedge clk);
         if (done_valid) begin
            ids[n] = int'(done_id);
            stamps[n] = cyc;
            n++;
            if (n == 6) #1 req_valid = '0;
         end
      end
      chk("fair_count", 32'(n), 6);
      for (int i = 0; i < 6; i++) chk("fair_order", 32'(ids[i]), 32'(exp_order[i]));
      for (int i = 1; i < 6; i++) chk("fair_spacing", 32'(stamps[i] - stamps[i-1]), 4);

      // 2. single request, len 5
      do_req(2, 5, 0, lat, did, dab);
      chk("single_lat", 32'(lat), 5);
      chk("single_id", 32'(did), 2);
      chk("single_abort", 32'(dab), 0);

      // 4. zero length behaves as length 1
      do_req(1, 0, 0, lat, did, dab);
      chk("zero_lat", 32'(lat), 1);
      chk("zero_id", 32'(did), 1);

      // 5. abort at cnt 3, then at cnt 1
      do_req(3, 8, 3, lat, did, dab);
      chk("abort3_lat", 32'(lat), 6);
      chk("abort3_id", 32'(did), 3);
      chk("abort3_flag", 32'(dab), 1);
      do_req(3, 8, 1, lat, did, dab);
      chk("abort1_lat", 32'(lat), 8);
      chk("abort1_flag", 32'(dab), 1);
      @(negedge clk);
      chk("abort_clear", 32'(done_abort), 0);
      chk("abort_idle", 32'(busy), 0);

      // 6. reset in the middle of an interval
      req_len[0 +: WIDTH] = 4'd10;
      req_valid = 4'b0001;
      hit = 1'b0;
      for (int k = 0; k < 30 && !hit; k++) begin
         @(negedge clk);
         if (req_ready[0]) hit = 1'b1;
      end
      if (!hit) timeout("rst_accept");
      @(posedge clk); #1;
      req_valid = '0;
      hit = 1'b0;
      for (int k = 0; k < 30 && !hit; k++) begin
         @(negedge clk);
         if (cnt_q == 4'd6) hit = 1'b1;
      end
      if (!hit) timeout("rst_cnt6");
      #2 rst = 1'b0;
      #1;
      chk("async_busy", 32'(busy), 0);
      chk("async_cnt", 32'(cnt_q), 0);
      chk("async_done", 32'(done_valid), 0);
      req_valid = '1;
      #1;
      chk("async_ready", 32'(req_ready), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", 32'(req_ready), 32'b0001);
      #1 req_valid = '0;
      repeat (15) @(posedge clk);
      #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/interval_timer_arbiter.md
Name: interval_timer_arbiter

Overview:
- Shares one WIDTH-bit down-counter between NREQ requesters. Each requester asks for an interval of req_len clock cycles.
- A round-robin arbiter grants the counter to one requester at a time. The block counts the interval down and returns a one-cycle done pulse tagged with the requester id.
- Sits between client FSMs and the free-running counter datapath. It replaces the ad-hoc per-client counters.

Parameters:
- NREQ, 4, number of requesters (2..16).
- WIDTH, 4, counter and interval width in bits.
- IDW, $clog2(NREQ), id width (derived localparam; not overridable).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- req_valid  in  NREQ  per-requester request.
- req_len  in  NREQ*WIDTH  packed interval lengths; requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready  out  NREQ  one-hot accept; combinational from state and pointer.
- abort  in  1  terminate the current interval early.
- busy  out  1  high in RUN and DONE.
- grant_id  out  IDW  id of the current or last granted requester.
- cnt_q  out  WIDTH  remaining count (observability).
- done_valid  out  1  one-cycle completion pulse.
- done_id  out  IDW  requester id, valid with done_valid.
- done_abort  out  1  high with done_valid if the interval was aborted.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, cnt_q=0, rr_ptr=0, grant_id=0, done_valid=0, done_id=0, done_abort=0, busy=0.
  - req_ready=0 while rst=0.
- FSM states: IDLE, RUN, DONE; encoding is held in the package.
- IDLE:
  - req_ready[i]=1 for exactly one i: the first asserted req_valid found scanning from rr_ptr upward with wrap.
  - All req_ready are 0 if no req_valid is asserted.
  - Accept happens on the edge where req_valid[i]&&req_ready[i]. On accept: cnt_q<=max(req_len[i],1), grant_id<=i, rr_ptr<=(i+1) mod NREQ, state<=RUN.
  - req_len=0 is treated as 1.
- RUN:
  - cnt_q decrements by 1 each cycle.
  - When cnt_q==1: cnt_q<=0 and state<=DONE.
  - All req_ready are 0.
- DONE:
  - done_valid=1, done_id=grant_id for exactly this one cycle.
  - Next state is IDLE.
  - Outputs are registered, decoded from state.
- Latency: for accepted length L≥1, done_valid is high during cycle L after the accept edge.
- Throughput: the next accept is possible 1 cycle after DONE, giving L+2 cycles per request.
- abort:
  - Sampled in RUN only. In RUN: state<=DONE, cnt_q<=0, and done_abort is set for the DONE cycle.
  - Ignored in IDLE and DONE.
  - If abort coincides with cnt_q==1, done_abort=1 (abort wins).
- done_abort: cleared on leaving DONE.
- Requesters:
  - Requesters may drop req_valid before being accepted; no penalty applies.
  - A requester may re-request in the IDLE cycle after its own DONE. Round-robin then favours the others.
- Reset mid-RUN: immediate return to IDLE. No done pulse is generated and the pending interval is lost.
- Counter arithmetic: unsigned. cnt_q never wraps below 0.

Decomposition:
- Shared package timer_pkg holds:
  - state enum/localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - the default WIDTH and NREQ.
- Sub-module rr_arbiter (NREQ): inputs req vector, ptr, enable; output one-hot gnt and encoded gnt_id. It is purely combinational.
- The pointer register and the FSM stay in the top.

Test Plan:
1. Reset release: drive rst=0 for 2 cycles, then rst=1 with no requests → all outputs 0, req_ready=0, busy=0.
2. Single request: req_valid[2]=1, req_len=5 → req_ready[2]=1 in IDLE; cnt_q steps 5,4,3,2,1,0; done_valid=1 with done_id=2 exactly 5 cycles after accept, done_abort=0.
3. Fairness: all four requesters hold req_valid with len=2 → grant order is 0,1,2,3,0,1. Each done pulse is spaced 4 cycles apart, and the done_id sequence matches the grant order.
4. Zero length: req_len[1]=0 → behaves as len 1; done_valid 1 cycle after accept with done_id=1.
5. Abort: req 3 with len 8; assert abort when cnt_q=3 → next cycle done_valid=1, done_id=3, done_abort=1; then IDLE. Repeat with abort at cnt_q==1 → done_abort=1.
6. Reset mid-run: req 0 with len 10; pull rst low at cnt_q=6 asynchronously, mid-cycle → outputs clear without waiting for an edge; no done_valid; after release, rr_ptr=0 and req 0 is granted first.
